// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, ALUOp classes and R-type funct values.
// Used by the ALU-control stage and the EX-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [2:0] OP_MEM   = 3'b000;
  localparam logic [2:0] OP_BR    = 3'b001;
  localparam logic [2:0] OP_ANDI  = 3'b010;
  localparam logic [2:0] OP_ORI   = 3'b011;
  localparam logic [2:0] OP_LUI   = 3'b100;
  localparam logic [2:0] OP_RTYPE = 3'b111;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;

  typedef struct packed {
    logic [3:0] op;
    logic       illegal;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_IDLE = '{op: ALU_NOP, illegal: 1'b0};

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decode of ALUOp class and R-type funct.
// Unsupported combinations yield the NOP code with illegal set.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_operation,
  output logic       illegal
);

  logic [3:0] rtype_op;
  logic       rtype_ill;

  always_comb begin
    rtype_op  = ALU_NOP;
    rtype_ill = 1'b0;
    unique case (1'b1)
      (funct == FN_ADD),
      (funct == FN_ADDU): rtype_op = ALU_ADD;
      (funct == FN_SUB),
      (funct == FN_SUBU): rtype_op = ALU_SUB;
      (funct == FN_AND):  rtype_op = ALU_AND;
      (funct == FN_OR):   rtype_op = ALU_OR;
      (funct == FN_NOR):  rtype_op = ALU_NOR;
      default:            rtype_ill = 1'b1;
    endcase
  end

  always_comb begin
    alu_operation = ALU_NOP;
    illegal       = 1'b0;
    unique case (1'b1)
      (alu_op == OP_MEM):  alu_operation = ALU_ADD;
      (alu_op == OP_BR):   alu_operation = ALU_SUB;
      (alu_op == OP_ANDI): alu_operation = ALU_AND;
      (alu_op == OP_ORI):  alu_operation = ALU_OR;
      (alu_op == OP_LUI):  alu_operation = ALU_LUI;
      (alu_op == OP_RTYPE): begin
        alu_operation = rtype_op;
        illegal       = rtype_ill;
      end
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decode, one-entry output buffer with
// valid/ready handshakes, flush, and a saturating illegal-entry counter.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ALUOperation,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  alu_ctrl_t        dec;
  alu_ctrl_t        ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  alu_ctrl_decode u_dec (
    .alu_op        (ALUOp),
    .funct         (funct),
    .alu_operation (dec.op),
    .illegal       (dec.illegal)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      ctrl_d  = CTRL_IDLE;
      valid_d = 1'b0;
    end else if (accept) begin
      ctrl_d  = dec;
      valid_d = 1'b1;
      if (dec.illegal && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q  <= CTRL_IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign ALUOperation  = ctrl_q.op;
  assign illegal       = ctrl_q.illegal;
  assign illegal_count = cnt_q;

endmodule
